// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: data port has priority, fetch is forced after STARVE_LIMIT denials.
// Optional conflict counter enabled by defining MEM_PORT_ARBITER_CONFLICT_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DWIDTH-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_be,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              sram_csn,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [DWIDTH-1:0] sram_di,
  input  logic [DWIDTH-1:0] sram_dout
`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  // state      | meaning
  // OWN_NONE   | no read issued last cycle
  // OWN_I      | last-cycle read belongs to fetch port
  // OWN_D      | last-cycle read belongs to data port
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       force_i;

  // Grants are suppressed while RST is high so nothing reaches the SRAM.
  always_comb begin
    force_i = i_req && (starve_q == LIMIT);
    d_gnt   = !RST && d_req && !force_i;
    i_gnt   = !RST && i_req && (!d_req || force_i);
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  always_comb begin
    i_rvalid  = !RST && (owner_q == OWN_I);
    d_rvalid  = !RST && (owner_q == OWN_D);
    i_rdata   = i_rvalid ? sram_dout : '0;
    d_rdata   = d_rvalid ? sram_dout : '0;
    sram_csn  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_be   = 4'b0000;
    sram_di   = '0;
    if (i_gnt) begin
      sram_csn  = 1'b0;
      sram_addr = i_addr;
      sram_be   = 4'b1111;
    end else if (d_gnt) begin
      sram_csn  = 1'b0;
      sram_wen  = !d_we;
      sram_addr = d_addr;
      sram_be   = d_be;
      sram_di   = d_wdata;
    end
  end

`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_q <= '0;
    end else if (i_req && d_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 1'b1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model with a behavioural SRAM.
module tb_mem_port_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          sram_csn, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_dout = '0;
`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
  logic [15:0]   conflict_cnt;
`endif

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .DWIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_di(sram_di), .sram_dout(sram_dout)
`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    case (a)
      'h010:   return 32'hDEADBEEF;
      'h030:   return 32'h0000000A;
      'h031:   return 32'h0000000B;
      default: return 32'hC0DE0000 | a;
    endcase
  endfunction

  // Behavioural SRAM responding to the DUT pins, one-cycle read latency.
  logic [DW-1:0] sram_mem [4096];
  bit            sram_wr  [4096];
  always @(posedge CLK) begin : sram_model
    logic [31:0] cur;
    if (!sram_csn) begin
      cur = sram_wr[sram_addr] ? sram_mem[sram_addr] : init_val(int'(sram_addr));
      if (sram_wen) begin
        sram_dout <= cur;
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) cur[8*b +: 8] = sram_di[8*b +: 8];
        sram_mem[sram_addr] <= cur;
        sram_wr[sram_addr]  <= 1'b1;
      end
    end
  end

  // Reference model state: consecutive fetch denials, the one outstanding read, memory image.
  int          den        = 0;
  int          pend_owner = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data  = '0;
  logic [31:0] ref_mem [int];
  int          conf       = 0;
  logic        last_i     = 1'b0;
  logic        last_d     = 1'b0;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_check();
    logic        e_i, e_d, e_csn, e_wen, e_iv, e_dv;
    logic [31:0] e_addr, e_be, e_di, v;
    e_i = 1'b0;
    e_d = 1'b0;
    if (!RST) begin
      e_d = d_req && !(i_req && den >= LIMIT);
      e_i = i_req && !e_d;
    end
    e_csn = 1'b1; e_wen = 1'b1; e_addr = 0; e_be = 0; e_di = 0;
    if (e_i) begin
      e_csn = 1'b0; e_addr = 32'(i_addr); e_be = 32'hF;
    end else if (e_d) begin
      e_csn = 1'b0; e_wen = !d_we; e_addr = 32'(d_addr); e_be = 32'(d_be); e_di = d_wdata;
    end
    e_iv = !RST && pend_owner == 1;
    e_dv = !RST && pend_owner == 2;
    chk("i_gnt", 32'(i_gnt), 32'(e_i));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));
    chk("sram_csn", 32'(sram_csn), 32'(e_csn));
    chk("sram_wen", 32'(sram_wen), 32'(e_wen));
    chk("sram_addr", 32'(sram_addr), e_addr);
    chk("sram_be", 32'(sram_be), e_be);
    chk("sram_di", sram_di, e_di);
    chk("i_rvalid", 32'(i_rvalid), 32'(e_iv));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
    chk("i_rdata", i_rdata, e_iv ? pend_data : 32'h0);
    chk("d_rdata", d_rdata, e_dv ? pend_data : 32'h0);
`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(conf));
`endif
    last_i = e_i;
    last_d = e_d;
    if (RST) begin
      den = 0; pend_owner = 0; conf = 0;
    end else begin
      if (e_i) begin
        pend_owner = 1; pend_data = ref_rd(int'(i_addr));
      end else if (e_d && !d_we) begin
        pend_owner = 2; pend_data = ref_rd(int'(d_addr));
      end else begin
        pend_owner = 0;
      end
      if (e_d && d_we) begin
        v = ref_rd(int'(d_addr));
        for (int b = 0; b < 4; b++)
          if (d_be[b]) v[8*b +: 8] = d_wdata[8*b +: 8];
        ref_mem[int'(d_addr)] = v;
      end
      den = (i_req && !e_i) ? ((den < LIMIT) ? den + 1 : LIMIT) : 0;
      if (i_req && d_req && conf < 65535) conf++;
    end
  endtask

  task automatic pre();
    @(negedge CLK);
    model_check();
  endtask

  task automatic post();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [4:0] cd, ci, civ;
    RST = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
    #1;
    repeat (2) begin
      pre();
      chk("rst csn", 32'(sram_csn), 32'h1);
      chk("rst wen", 32'(sram_wen), 32'h1);
      chk("rst d_gnt", 32'(d_gnt), 32'h0);
      post();
    end
    RST = 1'b0;

    // fetch only
    i_req = 1; i_addr = 'h010;
    pre();
    chk("fetch gnt", 32'(i_gnt), 32'h1);
    chk("fetch csn", 32'(sram_csn), 32'h0);
    chk("fetch wen", 32'(sram_wen), 32'h1);
    chk("fetch addr", 32'(sram_addr), 32'h010);
    post();
    i_req = 0;
    pre();
    chk("fetch rvalid", 32'(i_rvalid), 32'h1);
    chk("fetch rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch no d_rvalid", 32'(d_rvalid), 32'h0);
    post();

    // store
    d_req = 1; d_we = 1; d_addr = 'h020; d_be = 4'b0011; d_wdata = 32'h1234;
    pre();
    chk("store gnt", 32'(d_gnt), 32'h1);
    chk("store wen", 32'(sram_wen), 32'h0);
    chk("store be", 32'(sram_be), 32'h3);
    chk("store di", sram_di, 32'h1234);
    post();
    d_req = 0; d_we = 0;
    pre();
    chk("store no d_rvalid", 32'(d_rvalid), 32'h0);
    chk("store no i_rvalid", 32'(i_rvalid), 32'h0);
    post();

    // sustained conflict: fetch forced on the fourth cycle
    cd = 5'b10111; ci = 5'b01000; civ = 5'b10000;
    i_req = 1; i_addr = 'h005; d_req = 1; d_we = 0; d_addr = 'h006;
    for (int c = 0; c < 5; c++) begin
      pre();
      chk("conflict d_gnt", 32'(d_gnt), 32'(cd[c]));
      chk("conflict i_gnt", 32'(i_gnt), 32'(ci[c]));
      chk("conflict i_rvalid", 32'(i_rvalid), 32'(civ[c]));
      post();
    end
    i_req = 0; d_req = 0;
    pre(); post();

    // back-to-back fetch then load
    i_req = 1; i_addr = 'h030;
    pre();
    chk("b2b i_gnt", 32'(i_gnt), 32'h1);
    post();
    i_req = 0; d_req = 1; d_we = 0; d_addr = 'h031;
    pre();
    chk("b2b d_gnt", 32'(d_gnt), 32'h1);
    chk("b2b i_rvalid", 32'(i_rvalid), 32'h1);
    chk("b2b i_rdata", i_rdata, 32'hA);
    post();
    d_req = 0;
    pre();
    chk("b2b d_rvalid", 32'(d_rvalid), 32'h1);
    chk("b2b d_rdata", d_rdata, 32'hB);
    chk("b2b i_rvalid off", 32'(i_rvalid), 32'h0);
    post();

    // reset while a load is outstanding
    d_req = 1; d_addr = 'h031;
    pre();
    chk("rst-mid d_gnt", 32'(d_gnt), 32'h1);
    post();
    d_req = 0; RST = 1;
    pre();
    chk("rst-mid d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst-mid csn", 32'(sram_csn), 32'h1);
    chk("rst-mid wen", 32'(sram_wen), 32'h1);
    post();
    RST = 0;
    pre();
    chk("post-rst d_rvalid", 32'(d_rvalid), 32'h0);
    post();

`ifdef MEM_PORT_ARBITER_CONFLICT_CNT_EN
    RST = 1; pre(); post(); RST = 0;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 'h001; d_addr = 'h002;
    repeat (7) begin pre(); post(); end
    i_req = 0; d_req = 0;
    pre();
    chk("conflict_cnt 7", 32'(conflict_cnt), 32'd7);
    post();
    RST = 1; pre(); post(); RST = 0;
    pre();
    chk("conflict_cnt cleared", 32'(conflict_cnt), 32'd0);
    post();
`endif

    // randomized traffic; ungranted requests are held stable until granted
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      if (!(i_req && !last_i)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = AW'($urandom_range(0, 15));
      end
      if (!(d_req && !last_d)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 15));
        d_be    = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      pre();
      post();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
